// File: rtl/reg_pipe_if.sv
// Handshake bundle for reg_pipe.
//   D/DV/DR : input data, input valid, input ready (DR driven by the pipe)
//   Q/QV/QR : output data, output valid, output ready (QR driven by the sink)
//   CNT     : number of occupied stages, 0..DEPTH
// slave modport is the pipe side; master modport is the producer/consumer side.
interface reg_pipe_if #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned DEPTH      = 3
) ();
  logic [DATA_WIDTH-1:0]        D;
  logic                         DV;
  logic                         DR;
  logic [DATA_WIDTH-1:0]        Q;
  logic                         QV;
  logic                         QR;
  logic [$clog2(DEPTH+1)-1:0]   CNT;

  modport slave (
    input  D, DV, QR,
    output DR, Q, QV, CNT
  );

  modport master (
    output D, DV, QR,
    input  DR, Q, QV, CNT
  );
endinterface

// File: rtl/reg_pipe.sv
// reg_pipe: DEPTH-stage valid/ready register pipeline with bubble collapsing.
//   C    : clock, rising edge
//   R    : synchronous active-low reset
//   CLR  : synchronous flush, active-high (only with REG_PIPE_FLUSH_EN defined)
//   pipe : reg_pipe_if.slave (D/DV/DR input side, Q/QV/QR output side, CNT)
// Optional feature macro: REG_PIPE_FLUSH_EN adds the CLR port.
// Stage 0 takes input, stage DEPTH-1 drives Q/QV. A stage gives up its word when the
// stage after it is empty or is itself moving, so any empty stage lets input in.
module reg_pipe #(
  parameter int unsigned          DATA_WIDTH = 4,
  parameter int unsigned          DEPTH      = 3,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
  input logic       C,
  input logic       R,
`ifdef REG_PIPE_FLUSH_EN
  input logic       CLR,
`endif
  reg_pipe_if.slave pipe
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [DEPTH-1:0]      move;        // stage k hands its word onward this edge
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  flush;
  logic                  free_chain;  // ripples from output side toward stage 0
  logic                  dr;
  logic                  in_xfer;
  logic                  out_xfer;

`ifdef REG_PIPE_FLUSH_EN
  assign flush = CLR;
`else
  assign flush = 1'b0;
`endif

  always_comb begin
    move       = '0;
    free_chain = pipe.QR;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      move[k]    = valid_q[k] && free_chain;
      free_chain = !valid_q[k] || free_chain;
    end

    dr       = R && !flush && free_chain;
    in_xfer  = pipe.DV && dr;
    out_xfer = move[DEPTH-1];

    valid_d[0] = in_xfer || (valid_q[0] && !move[0]);
    data_d[0]  = in_xfer ? pipe.D : data_q[0];
    for (int k = 1; k < int'(DEPTH); k++) begin
      valid_d[k] = move[k-1] || (valid_q[k] && !move[k]);
      data_d[k]  = move[k-1] ? data_q[k-1] : data_q[k];
    end

    cnt_d = cnt_q + CntW'(in_xfer) - CntW'(out_xfer);
  end

  always_ff @(posedge C) begin
    if (!R) begin
      valid_q <= '0;
      cnt_q   <= '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        data_q[k] <= INIT_VAL;
      end
    end else if (flush) begin
      // Flush drops occupancy only; data registers keep their contents.
      valid_q <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  assign pipe.DR  = dr;
  assign pipe.Q   = data_q[DEPTH-1];
  assign pipe.QV  = valid_q[DEPTH-1] && !flush;
  assign pipe.CNT = cnt_q;

endmodule

// File: doc/reg_pipe.md
REG_PIPE -- requirements
Module: reg_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4: data bits per stage, >= 1.
REQ-002 SHALL have parameter DEPTH, default 3: number of register stages, >= 1.
REQ-003 SHALL have parameter INIT_VAL, default 0, DATA_WIDTH bits: value loaded into every stage data register on reset.
REQ-004 SHALL have port C, input, 1 bit: clock, all state updates on rising edge.
REQ-005 SHALL have port R, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have port D, input, DATA_WIDTH: input data.
REQ-007 SHALL have port DV, input, 1 bit: input valid.
REQ-008 SHALL have port DR, output, 1 bit: input ready.
REQ-009 SHALL have port Q, output, DATA_WIDTH: output data, equal to last-stage data register.
REQ-010 SHALL have port QV, output, 1 bit: output valid, equal to last-stage valid bit.
REQ-011 SHALL have port QR, input, 1 bit: output ready.
REQ-012 SHALL have port CNT, output, clog2(DEPTH+1) bits: number of valid stages, 0..DEPTH.

Function
REQ-013 SHALL hold per stage k (0..DEPTH-1) one data register and one valid bit; stage 0 is the input side, stage DEPTH-1 drives Q/QV.
REQ-014 SHALL define input transfer as DV=1 and DR=1 at a rising edge; output transfer as QV=1 and QR=1 at a rising edge.
REQ-015 SHALL let stage DEPTH-1 give up its word when QR=1; stage k<DEPTH-1 give up its word when stage k+1 is empty or gives up its own word (bubble collapsing).
REQ-016 SHALL drive DR=1 combinationally when stage 0 is empty or gives up its word, else 0.
REQ-017 SHALL load a stage data register only when the stage accepts a word; otherwise hold, including while invalid.
REQ-018 SHALL give latency DEPTH cycles through an empty pipeline with QR=1: word accepted at edge n appears with QV=1 after edge n+DEPTH-1... and is transferable at edge n+DEPTH.
REQ-019 SHALL sustain one transfer per cycle when DV=1 and QR=1 continuously.
REQ-020 SHALL, when full (CNT=DEPTH) with QR=0, drive DR=0 and hold all data and valid bits unchanged.
REQ-021 SHALL, when full with QR=1 and DV=1, perform input and output transfer at the same edge; CNT unchanged.
REQ-022 SHALL update CNT each edge as CNT + (input transfer) - (output transfer); never wraps.
REQ-023 SHALL preserve word order; no word duplicated or dropped.
REQ-024 SHALL keep Q stable while QV=1 and QR=0.

Reset
REQ-025 SHALL, at a rising edge with R=0, clear all valid bits, load INIT_VAL into all data registers, set CNT=0; Q=INIT_VAL, QV=0 thereafter.
REQ-026 SHALL drive DR=0 while R=0 and ignore DV/QR; DR=1 in the first cycle after R returns to 1.
REQ-027 SHALL discard all words held when reset asserts mid-operation; none emitted after reset.

Configuration
REQ-028 SHALL, with macro REG_PIPE_FLUSH_EN defined, add input port CLR, 1 bit, synchronous flush active-high.
REQ-029 SHALL, with REG_PIPE_FLUSH_EN defined and CLR=1 at an edge, clear all valid bits and CNT, keep data registers unchanged; DR=0 and QV=0 while CLR=1; no transfers occur; R=0 takes priority over CLR.
REQ-030 SHALL, without REG_PIPE_FLUSH_EN, have no CLR port and behave exactly per REQ-013..REQ-027.

Verification (DATA_WIDTH=8, DEPTH=3, INIT_VAL=8'hA5)
REQ-031 SHALL cover: R=0 for one edge -> Q=8'hA5, QV=0, CNT=0, DR=0 during R=0, DR=1 next cycle.
REQ-032 SHALL cover: QR=1, DV=1 streaming 8'h01..8'h05 from edge 0 -> QV=1 after edge 2, Q=01..05 on consecutive cycles, CNT=3 at steady state.
REQ-033 SHALL cover: QR=0, four words offered -> three accepted, DR=0 after third, CNT=3; then one cycle QR=1, DV=1 -> 8'h01 out, 4th word in, CNT=3.
REQ-034 SHALL cover: one word pushed with QR=0, three idle cycles, two more pushed -> all accepted via bubble collapse, CNT=3, output order preserved.
REQ-035 SHALL cover: R=0 at CNT=2 -> next cycle CNT=0, QV=0, Q=8'hA5; held words never appear on Q.
REQ-036 SHALL cover (REG_PIPE_FLUSH_EN): CLR=1 with CNT=3, DV=1, QR=1 -> DR=0, QV=0 that cycle, no word accepted, next cycle CNT=0.
